ras_stack: RTL and testbench

- Return address stack (RAS) for the fetch predictor unit.
- Fetch-stage predict logic pushes the link PC38 on each call and pops on each return; the popped top entry gives the predicted return target.
- Backend mispredict recovery restores the checkpointed pointer and count. An optional push in the same cycle covers a mispredicted call.
- The block sits beside the BTB/GBPT lookup and feeds the fetch PC select mux.

---
 rtl/ras_stack.sv | 95 +++++++++
 tb/tb_ras_stack.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ras_stack.sv
// Return address stack for fetch prediction: push on call, pop on return,
// checkpoint restore (with optional push) on backend mispredict recovery.
module ras_stack #(
    parameter int unsigned RAS_ENTRIES     = 16,
    parameter int unsigned LOG_RAS_ENTRIES = 4,
    parameter int unsigned PC_WIDTH        = 38
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       pop_valid,
    input  logic                       push_valid,
    input  logic [PC_WIDTH-1:0]        push_pc38,
    output logic                       ret_valid,
    output logic [PC_WIDTH-1:0]        ret_pc38,
    output logic [LOG_RAS_ENTRIES-1:0] ras_index,
    output logic [LOG_RAS_ENTRIES:0]   ras_count,
    input  logic                       restore_valid,
    input  logic [LOG_RAS_ENTRIES-1:0] restore_index,
    input  logic [LOG_RAS_ENTRIES:0]   restore_count,
    input  logic                       restore_push_valid,
    input  logic [PC_WIDTH-1:0]        restore_push_pc38
);

    localparam int unsigned CW = LOG_RAS_ENTRIES + 1;
    localparam logic [CW-1:0]              CNT_FULL = CW'(RAS_ENTRIES);
    localparam logic [LOG_RAS_ENTRIES-1:0] IDX_ONE  = LOG_RAS_ENTRIES'(1);
    localparam logic [CW-1:0]              CNT_ONE  = CW'(1);

    logic [PC_WIDTH-1:0]        r_entry [RAS_ENTRIES];
    logic [LOG_RAS_ENTRIES-1:0] r_top_idx;
    logic [CW-1:0]              r_count;

    logic [LOG_RAS_ENTRIES-1:0] w_top_nxt;
    logic [CW-1:0]              w_count_nxt;
    logic [CW-1:0]              w_rst_cnt;
    logic                       w_wr_en;
    logic [LOG_RAS_ENTRIES-1:0] w_wr_idx;
    logic [PC_WIDTH-1:0]        w_wr_data;

    assign ret_pc38  = r_entry[r_top_idx];
    assign ret_valid = (r_count != '0);
    assign ras_index = r_top_idx;
    assign ras_count = r_count;

    assign w_rst_cnt = (restore_count > CNT_FULL) ? CNT_FULL : restore_count;

    always_comb begin
        w_top_nxt   = r_top_idx;
        w_count_nxt = r_count;
        w_wr_en     = 1'b0;
        w_wr_idx    = r_top_idx;
        w_wr_data   = push_pc38;
        if (restore_valid) begin
            if (restore_push_valid) begin
                w_top_nxt   = restore_index + IDX_ONE;
                w_wr_en     = 1'b1;
                w_wr_idx    = restore_index + IDX_ONE;
                w_wr_data   = restore_push_pc38;
                w_count_nxt = (w_rst_cnt == CNT_FULL) ? CNT_FULL : w_rst_cnt + CNT_ONE;
            end else begin
                w_top_nxt   = restore_index;
                w_count_nxt = w_rst_cnt;
            end
        end else if (push_valid && pop_valid) begin
            // return+call: overwrite the current top in place
            w_wr_en = 1'b1;
        end else if (push_valid) begin
            w_top_nxt   = r_top_idx + IDX_ONE;
            w_wr_en     = 1'b1;
            w_wr_idx    = r_top_idx + IDX_ONE;
            w_count_nxt = (r_count == CNT_FULL) ? CNT_FULL : r_count + CNT_ONE;
        end else if (pop_valid) begin
            // pointer wraps even on underflow so checkpoints stay consistent
            w_top_nxt   = r_top_idx - IDX_ONE;
            w_count_nxt = (r_count == '0) ? '0 : r_count - CNT_ONE;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int unsigned i = 0; i < RAS_ENTRIES; i++) begin
                r_entry[i] <= '0;
            end
            r_top_idx <= '0;
            r_count   <= '0;
        end else begin
            if (w_wr_en) begin
                r_entry[w_wr_idx] <= w_wr_data;
            end
            r_top_idx <= w_top_nxt;
            r_count   <= w_count_nxt;
        end
    end

endmodule

// File: tb/tb_ras_stack.sv
// Directed self-checking bench for ras_stack: push/pop, overflow, underflow,
// replace-top, checkpoint restore and asynchronous reset.
module tb_ras_stack;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        pop_valid = 1'b0;
    logic        push_valid = 1'b0;
    logic [37:0] push_pc38 = '0;
    logic        ret_valid;
    logic [37:0] ret_pc38;
    logic [3:0]  ras_index;
    logic [4:0]  ras_count;
    logic        restore_valid = 1'b0;
    logic [3:0]  restore_index = '0;
    logic [4:0]  restore_count = '0;
    logic        restore_push_valid = 1'b0;
    logic [37:0] restore_push_pc38 = '0;

    int n_checks = 0;
    int n_errors = 0;

    ras_stack #(.RAS_ENTRIES(16), .LOG_RAS_ENTRIES(4), .PC_WIDTH(38)) dut (
        .CLK(CLK), .RST(RST),
        .pop_valid(pop_valid), .push_valid(push_valid), .push_pc38(push_pc38),
        .ret_valid(ret_valid), .ret_pc38(ret_pc38),
        .ras_index(ras_index), .ras_count(ras_count),
        .restore_valid(restore_valid), .restore_index(restore_index),
        .restore_count(restore_count), .restore_push_valid(restore_push_valid),
        .restore_push_pc38(restore_push_pc38)
    );

    always #5 CLK = ~CLK;

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle;
        pop_valid = 1'b0; push_valid = 1'b0; restore_valid = 1'b0;
        restore_push_valid = 1'b0;
    endtask

    task automatic do_reset;
        idle();
        tick();
        RST = 1'b1;
        #2;
        RST = 1'b0;
        #1;
    endtask

    task automatic push(input logic [37:0] pc);
        push_valid = 1'b1; push_pc38 = pc; tick(); idle();
    endtask

    task automatic pop;
        pop_valid = 1'b1; tick(); idle();
    endtask

    task automatic test_reset;
        RST = 1'b1;
        #3;
        if ({ret_valid, ras_count, ras_index, ret_pc38} !== {1'b0, 5'd0, 4'd0, 38'h0}) begin
            $display("FAIL reset_held got v=%0d c=%0d i=%0d pc=%h exp 0/0/0/0", ret_valid, ras_count, ras_index, ret_pc38);
            n_errors++;
        end
        n_checks++;
        #4 RST = 1'b0;
        tick();
        if ({ret_valid, ras_count, ras_index, ret_pc38} !== {1'b0, 5'd0, 4'd0, 38'h0}) begin
            $display("FAIL reset_release got v=%0d c=%0d i=%0d pc=%h exp 0/0/0/0", ret_valid, ras_count, ras_index, ret_pc38);
            n_errors++;
        end
        n_checks++;
    endtask

    task automatic test_push_pop;
        do_reset();
        push(38'h1000); push(38'h2000); push(38'h3000);
        if ({ret_valid, ras_count, ras_index, ret_pc38} !== {1'b1, 5'd3, 4'd3, 38'h3000}) begin
            $display("FAIL push3 got v=%0d c=%0d i=%0d pc=%h exp 1/3/3/3000", ret_valid, ras_count, ras_index, ret_pc38);
            n_errors++;
        end
        n_checks++;
        pop();
        if ({ret_valid, ras_count, ras_index, ret_pc38} !== {1'b1, 5'd2, 4'd2, 38'h2000}) begin
            $display("FAIL pop1 got v=%0d c=%0d i=%0d pc=%h exp 1/2/2/2000", ret_valid, ras_count, ras_index, ret_pc38);
            n_errors++;
        end
        n_checks++;
        pop();
        if ({ret_valid, ras_count, ras_index, ret_pc38} !== {1'b1, 5'd1, 4'd1, 38'h1000}) begin
            $display("FAIL pop2 got v=%0d c=%0d i=%0d pc=%h exp 1/1/1/1000", ret_valid, ras_count, ras_index, ret_pc38);
            n_errors++;
        end
        n_checks++;
    endtask

    task automatic test_overflow;
        do_reset();
        for (int k = 0; k < 17; k++) push(38'(32'h100 + k));
        if ({ret_valid, ras_count, ras_index, ret_pc38} !== {1'b1, 5'd16, 4'd1, 38'h110}) begin
            $display("FAIL overflow got v=%0d c=%0d i=%0d pc=%h exp 1/16/1/110", ret_valid, ras_count, ras_index, ret_pc38);
            n_errors++;
        end
        n_checks++;
        pop();
        if ({ret_valid, ras_count, ras_index, ret_pc38} !== {1'b1, 5'd15, 4'd0, 38'h10F}) begin
            $display("FAIL overflow_pop1 got v=%0d c=%0d i=%0d pc=%h exp 1/15/0/10f", ret_valid, ras_count, ras_index, ret_pc38);
            n_errors++;
        end
        n_checks++;
        for (int k = 0; k < 15; k++) pop();
        if ({ret_valid, ras_count, ras_index} !== {1'b0, 5'd0, 4'd1}) begin
            $display("FAIL overflow_drain got v=%0d c=%0d i=%0d exp 0/0/1", ret_valid, ras_count, ras_index);
            n_errors++;
        end
        n_checks++;
    endtask

    task automatic test_underflow;
        do_reset();
        pop();
        if ({ret_valid, ras_count, ras_index} !== {1'b0, 5'd0, 4'd15}) begin
            $display("FAIL underflow got v=%0d c=%0d i=%0d exp 0/0/15", ret_valid, ras_count, ras_index);
            n_errors++;
        end
        n_checks++;
        push(38'hABC);
        if ({ret_valid, ras_count, ras_index, ret_pc38} !== {1'b1, 5'd1, 4'd0, 38'hABC}) begin
            $display("FAIL underflow_push got v=%0d c=%0d i=%0d pc=%h exp 1/1/0/abc", ret_valid, ras_count, ras_index, ret_pc38);
            n_errors++;
        end
        n_checks++;
        do_reset();
        push_valid = 1'b1; pop_valid = 1'b1; push_pc38 = 38'h5; tick(); idle();
        if ({ret_valid, ras_count, ras_index, ret_pc38} !== {1'b0, 5'd0, 4'd0, 38'h5}) begin
            $display("FAIL replace_empty got v=%0d c=%0d i=%0d pc=%h exp 0/0/0/5", ret_valid, ras_count, ras_index, ret_pc38);
            n_errors++;
        end
        n_checks++;
    endtask

    task automatic test_replace_top;
        do_reset();
        push(38'hA); push(38'hB);
        push_valid = 1'b1; pop_valid = 1'b1; push_pc38 = 38'hC; tick(); idle();
        if ({ret_valid, ras_count, ras_index, ret_pc38} !== {1'b1, 5'd2, 4'd2, 38'hC}) begin
            $display("FAIL replace_top got v=%0d c=%0d i=%0d pc=%h exp 1/2/2/c", ret_valid, ras_count, ras_index, ret_pc38);
            n_errors++;
        end
        n_checks++;
        pop();
        if ({ras_count, ras_index, ret_pc38} !== {5'd1, 4'd1, 38'hA}) begin
            $display("FAIL replace_below got c=%0d i=%0d pc=%h exp 1/1/a", ras_count, ras_index, ret_pc38);
            n_errors++;
        end
        n_checks++;
    endtask

    task automatic test_restore;
        do_reset();
        push(38'hA); push(38'hB);
        push(38'hD); push(38'hE); pop();
        if ({ras_count, ras_index, ret_pc38} !== {5'd3, 4'd3, 38'hD}) begin
            $display("FAIL pre_restore got c=%0d i=%0d pc=%h exp 3/3/d", ras_count, ras_index, ret_pc38);
            n_errors++;
        end
        n_checks++;
        restore_valid = 1'b1; restore_index = 4'd2; restore_count = 5'd2;
        push_valid = 1'b1; push_pc38 = 38'h999; tick(); idle();
        if ({ret_valid, ras_count, ras_index, ret_pc38} !== {1'b1, 5'd2, 4'd2, 38'hB}) begin
            $display("FAIL restore got v=%0d c=%0d i=%0d pc=%h exp 1/2/2/b", ret_valid, ras_count, ras_index, ret_pc38);
            n_errors++;
        end
        n_checks++;
        restore_valid = 1'b1; restore_push_valid = 1'b1; restore_index = 4'd2;
        restore_count = 5'd2; restore_push_pc38 = 38'h777; tick(); idle();
        if ({ret_valid, ras_count, ras_index, ret_pc38} !== {1'b1, 5'd3, 4'd3, 38'h777}) begin
            $display("FAIL restore_push got v=%0d c=%0d i=%0d pc=%h exp 1/3/3/777", ret_valid, ras_count, ras_index, ret_pc38);
            n_errors++;
        end
        n_checks++;
        restore_valid = 1'b1; restore_push_valid = 1'b1; restore_index = 4'd2;
        restore_count = 5'd16; restore_push_pc38 = 38'h888; tick(); idle();
        if ({ras_count, ras_index, ret_pc38} !== {5'd16, 4'd3, 38'h888}) begin
            $display("FAIL restore_push_full got c=%0d i=%0d pc=%h exp 16/3/888", ras_count, ras_index, ret_pc38);
            n_errors++;
        end
        n_checks++;
        // E still sits in entry 4 from before the pop; restore re-exposes it
        restore_valid = 1'b1; restore_index = 4'd4; restore_count = 5'd20; tick(); idle();
        if ({ras_count, ras_index, ret_pc38} !== {5'd16, 4'd4, 38'hE}) begin
            $display("FAIL restore_clamp got c=%0d i=%0d pc=%h exp 16/4/e", ras_count, ras_index, ret_pc38);
            n_errors++;
        end
        n_checks++;
    endtask

    task automatic test_async_reset;
        do_reset();
        push(38'h42); push(38'h43);
        push_valid = 1'b1; push_pc38 = 38'h55;
        #2;
        RST = 1'b1;
        #1;
        if ({ret_valid, ras_count, ras_index, ret_pc38} !== {1'b0, 5'd0, 4'd0, 38'h0}) begin
            $display("FAIL async_reset got v=%0d c=%0d i=%0d pc=%h exp 0/0/0/0", ret_valid, ras_count, ras_index, ret_pc38);
            n_errors++;
        end
        n_checks++;
        tick();
        if ({ret_valid, ras_count, ras_index, ret_pc38} !== {1'b0, 5'd0, 4'd0, 38'h0}) begin
            $display("FAIL reset_over_edge got v=%0d c=%0d i=%0d pc=%h exp 0/0/0/0", ret_valid, ras_count, ras_index, ret_pc38);
            n_errors++;
        end
        n_checks++;
        idle();
        #2 RST = 1'b0;
        push(38'h99);
        if ({ret_valid, ras_count, ras_index, ret_pc38} !== {1'b1, 5'd1, 4'd1, 38'h99}) begin
            $display("FAIL post_reset_push got v=%0d c=%0d i=%0d pc=%h exp 1/1/1/99", ret_valid, ras_count, ras_index, ret_pc38);
            n_errors++;
        end
        n_checks++;
    endtask

    initial begin
        test_reset();
        test_push_pop();
        test_overflow();
        test_underflow();
        test_replace_top();
        test_restore();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
